vedic_seq_mult8: RTL and testbench

//  Sequential 2H x 2H Vedic multiplier (default 8x8) built on one combinational H x H

---
 rtl/vedic_seq_mult8_pkg.sv | 15 +
 rtl/vedic_half_mult.sv | 27 ++
 rtl/vedic_seq_mult8.sv | 97 +++++++++
 tb/tb_vedic_seq_mult8.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/vedic_seq_mult8_pkg.sv
// Shared definitions for the sequential Vedic multiplier: FSM state encoding and default half width.
package vedic_seq_mult8_pkg;

  localparam int HALF_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PP0  = 3'd1,
    PP1  = 3'd2,
    PP2  = 3'd3,
    PP3  = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/vedic_half_mult.sv
// Combinational H x H Urdhva-Tiryakbhyam multiplier: column k collects every
// crosswise bit product x[i]&y[j] with i+j==k, and the weighted column sums are added.
module vedic_half_mult #(
  parameter int HALF_W = 4
) (
  input  logic [HALF_W-1:0]   x,
  input  logic [HALF_W-1:0]   y,
  output logic [2*HALF_W-1:0] p
);

  localparam int PW = 2 * HALF_W;

  logic [PW-1:0] col;

  always_comb begin
    p   = '0;
    col = '0;
    for (int k = 0; k < PW - 1; k++) begin
      col = '0;
      for (int i = 0; i < HALF_W; i++)
        for (int j = 0; j < HALF_W; j++)
          if (i + j == k) col = col + PW'(x[i] & y[j]);
      p = p + (col << k);
    end
  end

endmodule

// File: rtl/vedic_seq_mult8.sv
// Sequential 2H x 2H Vedic multiplier: one shared H x H half-multiplier, four
// half-products folded into a 4H-bit accumulator over PP0..PP3, valid/ready on both sides.
module vedic_seq_mult8
  import vedic_seq_mult8_pkg::*;
#(
  parameter int HALF_W = HALF_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*HALF_W-1:0]   a,
  input  logic [2*HALF_W-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*HALF_W-1:0]   product,
  output logic                  busy
);

  localparam int OW = 2 * HALF_W;
  localparam int AW = 3 * HALF_W;
  localparam int PW = 4 * HALF_W;

  state_t          state, state_nxt;
  logic [OW-1:0]   opa, opb;
  logic [PW-1:0]   acc;
  logic [HALF_W-1:0] hx, hy;
  logic [OW-1:0]   hp;
  logic [AW-1:0]   addend, acc_hi_nxt;

  // Operand halves routed to the single half-multiplier by phase.
  always_comb begin
    hx = opa[HALF_W-1:0];
    hy = opb[HALF_W-1:0];
    unique case (state)
      PP1:     begin hx = opa[OW-1:HALF_W]; hy = opb[HALF_W-1:0];  end
      PP2:     begin hx = opa[HALF_W-1:0];  hy = opb[OW-1:HALF_W]; end
      PP3:     begin hx = opa[OW-1:HALF_W]; hy = opb[OW-1:HALF_W]; end
      default: ;
    endcase
  end

  vedic_half_mult #(.HALF_W(HALF_W)) u_half (.x(hx), .y(hy), .p(hp));

  // The AH*BH term carries an extra weight of 2^H relative to the cross terms.
  assign addend     = (state == PP3) ? (AW'(hp) << HALF_W) : AW'(hp);
  assign acc_hi_nxt = acc[PW-1:HALF_W] + addend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa     <= '0;
      opb     <= '0;
      acc     <= '0;
      product <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          opa <= a;
          opb <= b;
          acc <= '0;
        end
        PP0:      acc <= PW'(hp);
        PP1, PP2: acc[PW-1:HALF_W] <= acc_hi_nxt;
        PP3: begin
          acc[PW-1:HALF_W] <= acc_hi_nxt;
          product          <= {acc_hi_nxt, acc[HALF_W-1:0]};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = PP0;
      PP0:     state_nxt = PP1;
      PP1:     state_nxt = PP2;
      PP2:     state_nxt = PP3;
      PP3:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_vedic_seq_mult8.sv
// Self-checking bench: directed literal products plus random traffic against a
// handshake-level model (product = a*b, fixed five-cycle visibility of out_valid).
module tb_vedic_seq_mult8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  a, b;
  logic [15:0] product;

  int checks   = 0;
  int failures = 0;

  vedic_seq_mult8 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: ph<0 means idle; otherwise ph counts cycles since the accept decision.
  int          ph = -1;
  logic [15:0] exp_p;
  logic [15:0] last_prod = 16'h0;
  int          n_acc = 0, n_out = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (ph >= 0) n_acc--;
      ph        = -1;
      last_prod = 16'h0;
    end else if (ph < 0) begin
      chk("idle_in_ready", in_ready, 1);
      chk("idle_busy", busy, 0);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_product_hold", product, last_prod);
      if (in_valid) begin
        exp_p = 16'(a) * 16'(b);
        ph    = 0;
        n_acc++;
      end
    end else begin
      ph++;
      chk("busy_in_ready", in_ready, 0);
      chk("busy_busy", busy, 1);
      chk("out_valid_timing", out_valid, (ph >= 5) ? 1 : 0);
      if (out_valid) begin
        chk("product", product, exp_p);
        if (out_ready) begin
          ph        = -1;
          last_prod = exp_p;
          n_out++;
        end
      end
    end
  end

  task automatic run_op(input logic [7:0] ai, input logic [7:0] bi, input logic [15:0] expv,
                        input int bp, input bit tog);
    int n;
    @(posedge clk); #1;
    a = ai; b = bi; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 50);
    chk("accept_timeout", (n < 50) ? 1 : 0, 1);
    @(posedge clk); #1;
    if (!tog) in_valid = 1'b0;
    n = 0;
    while (1) begin
      @(negedge clk); n++;
      if (out_valid || n >= 20) break;
      @(posedge clk); #1;
      if (tog) begin a = 8'($urandom); b = 8'($urandom); end
    end
    chk("latency", n, 5);
    chk("lit_product", product, expv);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (bp) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int cyc, target;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 8'h0; b = 8'h0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_product", product, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    run_op(8'hFF, 8'hFF, 16'hFE01, 0, 1'b0);
    run_op(8'hA5, 8'h3C, 16'h26AC, 0, 1'b0);
    run_op(8'h00, 8'h7F, 16'h0000, 0, 1'b0);
    run_op(8'h0F, 8'hF0, 16'h0E10, 10, 1'b0);
    run_op(8'h81, 8'hC3, 16'h6243, 2, 1'b1);
    run_op(8'hFF, 8'h01, 16'h00FF, 0, 1'b0);

    // Abort in PP2: outputs must clear on the reset edge itself.
    @(posedge clk); #1;
    a = 8'h55; b = 8'hAA; in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_product", product, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    run_op(8'h12, 8'h34, 16'h03A8, 0, 1'b0);

    target = n_out + 1000;
    cyc = 0;
    while (n_out < target && cyc < 20000) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      b = 8'($urandom);
      cyc++;
    end
    chk("random_done", (n_out >= target) ? 1 : 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("no_drop_dup", n_out, n_acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
